demux_1x2_32bit_buf: RTL and testbench

Buffered 1-to-2 demultiplexer for 32-bit words. It is the distribution counterpart of the 2x1 32-bit select path. One valid/ready input channel carries a word plus a select bit. The word is steered into one of two independent FIFO-buffered output channels. It sits between a single producer (e.g. write-back/result bus) and two consumers that drain at different rates.

---
 rtl/demux_1x2_32bit_buf_pkg.sv | 15 +
 rtl/demux_1x2_32bit_buf_if.sv | 39 +++
 rtl/demux_1x2_32bit_buf_fifo.sv | 79 +++++++
 rtl/demux_1x2_32bit_buf.sv | 52 +++++
 tb/tb_demux_1x2_32bit_buf.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/demux_1x2_32bit_buf_pkg.sv
// Shared constants and types for the buffered 1-to-2 word demultiplexer.
package demux_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef logic [DATA_W-1:0] word_t;

    // Output channel chosen by the input select bit.
    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } sel_e;

endpackage

// File: rtl/demux_1x2_32bit_buf_if.sv
// Handshake bundle between the single producer, the demux and its two consumers.
interface demux_1x2_32bit_buf_if
    import demux_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) ();

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    word_t         in_data;
    logic          in_select;

    logic          out0_valid;
    logic          out0_ready;
    word_t         out0_data;
    logic [CW-1:0] out0_count;

    logic          out1_valid;
    logic          out1_ready;
    word_t         out1_data;
    logic [CW-1:0] out1_count;

    // Environment side: producer plus both consumers.
    modport master (
        output in_valid, in_data, in_select, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_count,
               out1_valid, out1_data, out1_count
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_select, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_count,
               out1_valid, out1_data, out1_count
    );

endinterface

// File: rtl/demux_1x2_32bit_buf_fifo.sv
// Single output buffer: DEPTH-entry circular FIFO with registered count,
// full and empty flags and a valid/ready head interface.
module demux_fifo_32bit
    import demux_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  word_t         push_data,
    input  logic          pop_ready,
    output logic          out_valid,
    output word_t         out_data,
    output logic [CW-1:0] count,
    output logic          full
);

    localparam int unsigned AW = $clog2(DEPTH);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses pushes even when popping; reads while empty are ignored.
    assign do_push = push & ~full_q;
    assign do_pop  = pop_ready & ~empty_q;

    // Next occupancy: push and pop together leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and flags; flags are derived from the next count so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign out_valid = ~empty_q;
    assign out_data  = mem[rd_ptr];
    assign count     = cnt_q;
    assign full      = full_q;

endmodule

// File: rtl/demux_1x2_32bit_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into one of two
// independent FIFOs selected by in_select.
module demux_1x2_32bit_buf
    import demux_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    demux_1x2_32bit_buf_if.slave bus
);

    sel_e sel;
    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    assign sel = sel_e'(bus.in_select);

    // Ready depends only on the selected FIFO's registered full flag.
    assign bus.in_ready = (sel == SEL_OUT1) ? ~full1 : ~full0;
    assign accept       = bus.in_valid & bus.in_ready;
    assign push0        = accept & (sel == SEL_OUT0);
    assign push1        = accept & (sel == SEL_OUT1);

    demux_fifo_32bit #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (bus.in_data),
        .pop_ready (bus.out0_ready),
        .out_valid (bus.out0_valid),
        .out_data  (bus.out0_data),
        .count     (bus.out0_count),
        .full      (full0)
    );

    demux_fifo_32bit #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (bus.in_data),
        .pop_ready (bus.out1_ready),
        .out_valid (bus.out1_valid),
        .out_data  (bus.out1_data),
        .count     (bus.out1_count),
        .full      (full1)
    );

endmodule

// File: tb/tb_demux_1x2_32bit_buf.sv
// Bench for demux_1x2_32bit_buf: directed scenarios plus randomized traffic,
// checked by a negedge monitor against per-output reference queues.
module tb_demux_1x2_32bit_buf;
    import demux_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    word_t q0[$];
    word_t q1[$];

    always #5 clk = ~clk;

    demux_1x2_32bit_buf_if #(.DEPTH(DEPTH)) bus ();

    demux_1x2_32bit_buf #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a word is visible the cycle after it is accepted, the
    // selected queue accepts while it holds fewer than DEPTH words, and a
    // consumer takes the head when ready and something is queued.
    always @(negedge clk) begin
        bit exp_rdy;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
            chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
            chk("rst_out0_count", 32'(bus.out0_count), 32'd0);
            chk("rst_out1_count", 32'(bus.out1_count), 32'd0);
        end else begin
            exp_rdy = bus.in_select ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
            chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
            chk("out0_count", 32'(bus.out0_count), 32'(q0.size()));
            chk("out1_count", 32'(bus.out1_count), 32'(q1.size()));
            if (q0.size() != 0) chk("out0_data", bus.out0_data, q0[0]);
            if (q1.size() != 0) chk("out1_data", bus.out1_data, q1[0]);
            if (bus.out0_ready && q0.size() != 0) void'(q0.pop_front());
            if (bus.out1_ready && q1.size() != 0) void'(q1.pop_front());
            if (bus.in_valid && exp_rdy) begin
                if (bus.in_select) q1.push_back(bus.in_data);
                else               q0.push_back(bus.in_data);
            end
        end
    end

    initial begin
        bit stalled;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_select  = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("init_in_ready", 32'(bus.in_ready), 32'd1);

        // Single word to output 0, held there.
        bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.in_select = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("first_valid", 32'(bus.out0_valid), 32'd1);
        chk("first_data", bus.out0_data, 32'hDEADBEEF);
        chk("first_count", 32'(bus.out0_count), 32'd1);
        chk("first_out1_valid", 32'(bus.out1_valid), 32'd0);

        // Fill output 1, then ready follows the select only.
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(i); bus.in_select = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_select = 1'b1;
        #1 chk("full1_ready_sel1", 32'(bus.in_ready), 32'd0);
        bus.in_select = 1'b0;
        #1 chk("full1_ready_sel0", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_data = 32'hA5;
        step();
        bus.in_valid = 1'b0;
        chk("a5_count0", 32'(bus.out0_count), 32'd2);
        chk("a5_count1", 32'(bus.out1_count), 32'd4);

        // Full output 0 with simultaneous pop: no accept that cycle.
        bus.in_valid = 1'b1; bus.in_data = 32'h11; step();
        bus.in_data = 32'h22; step();
        chk("full0_count", 32'(bus.out0_count), 32'd4);
        bus.in_data = 32'h77; bus.out0_ready = 1'b1;
        #1 chk("full0_pop_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.out0_ready = 1'b0;
        chk("full0_after_pop", 32'(bus.out0_count), 32'd3);
        chk("full0_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("full0_refill", 32'(bus.out0_count), 32'd4);

        // Drain both.
        bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
        repeat (6) step();
        chk("drain_count0", 32'(bus.out0_count), 32'd0);
        chk("drain_count1", 32'(bus.out1_count), 32'd0);

        // Streaming alternate selects with both consumers always ready.
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'(i); bus.in_select = i[0];
            step();
            chk("stream_visible", 32'(i[0] ? bus.out1_valid : bus.out0_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        repeat (2) step();
        chk("stream_count0", 32'(bus.out0_count), 32'd0);
        chk("stream_count1", 32'(bus.out1_count), 32'd0);

        // Push into empty output 0 while its consumer is already ready.
        bus.in_valid = 1'b1; bus.in_data = 32'h1234; bus.in_select = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("empty_push_count", 32'(bus.out0_count), 32'd1);
        chk("empty_push_data", bus.out0_data, 32'h1234);
        step();
        chk("empty_push_drained", 32'(bus.out0_count), 32'd0);

        // Randomized traffic with a slow consumer on output 1.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            stalled = bus.in_valid & ~bus.in_ready;
            @(posedge clk);
            #1;
            if (!stalled) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_data   = $urandom;
                bus.in_select = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 7) == 0) begin
                bus.in_select = ~bus.in_select;
            end
            bus.out0_ready = ($urandom % 4) != 0;
            bus.out1_ready = ($urandom % 3) == 0;
        end
        bus.in_valid = 1'b0;
        bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
        repeat (8) step();

        // Reset with words buffered in both outputs.
        bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'h100 + 32'(i); bus.in_select = (i >= 3);
            step();
        end
        bus.in_valid = 1'b0;
        chk("prerst_count0", 32'(bus.out0_count), 32'd3);
        chk("prerst_count1", 32'(bus.out1_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid0", 32'(bus.out0_valid), 32'd0);
        chk("async_valid1", 32'(bus.out1_valid), 32'd0);
        chk("async_count0", 32'(bus.out0_count), 32'd0);
        chk("async_count1", 32'(bus.out1_count), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_valid0", 32'(bus.out0_valid), 32'd0);
        chk("post_rst_valid1", 32'(bus.out1_valid), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
